pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Hazard and stall controller for the five-stage pipeline. It drives the hold and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It sequences three conditions: load-use interlock, multi-cycle multiply/divide occupancy, and data-memory wait states with a timeout. It also flushes IF/ID on taken branches and keeps a stall-cycle counter for performance monitoring.

## Interface
- MUL_CYCLES, 5: multiply latency in cycles, 1..15
- DIV_CYCLES, 10: divide latency in cycles, 1..15
- MEM_TIMEOUT, 64: maximum consecutive data-memory wait cycles before the wait is forced to release, 2..255
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rs_D, rt_D  in  5 each  source register numbers of the instruction in D
- use_rs_D, use_rt_D  in  1 each  D instruction reads rs/rt
- load_E  in  1  E instruction is a load
- wa_E  in  5  destination register of the E instruction
- mdu_start_E  in  1  mult/div issuing in E this cycle
- mdu_div_E  in  1  issuing operation is a divide (valid with mdu_start_E)
- mdu_use_D  in  1  D instruction is mfhi/mflo/mthi/mtlo/mult/div
- branch_taken_D  in  1  branch/jump in D resolved taken
- dm_req_M  in  1  M stage is accessing data memory
- dm_ready  in  1  data memory completes the access this cycle
- stall_pc, stall_d, stall_e, stall_m, stall_w  out  1 each  hold the PC and the corresponding pipe register (1 = hold; wired to the registers' en)
- flush_d, flush_e, flush_w  out  1 each  clear IF/ID, ID/EX, MEM/WB on the next edge (wired to the registers' rst)
- mdu_busy  out  1  MDU counter nonzero
- bus_err  out  1  one-cycle pulse when a memory timeout fires
- stall_count  out  32  total cycles with stall_pc=1 since reset, wraps

## Operation
- Sequential state: mdu_cnt[3:0], state {IDLE, MEM_WAIT}, wait_cnt[7:0], bus_err, stall_count.
- Stall and flush outputs are combinational from the inputs and the sequential state.
- **memfreeze** = dm_req_M & ~dm_ready & ~timeout_hit.
  - timeout_hit = (state==MEM_WAIT) & (wait_cnt==MEM_TIMEOUT-1).
- **lu** = load_E & wa_E!=0 & ((use_rs_D & rs_D==wa_E) | (use_rt_D & rt_D==wa_E)).
- **mdu_hz** = mdu_use_D & (mdu_cnt!=0 | mdu_start_E).
- Output priority, highest first:
  - memfreeze: stall_pc=stall_d=stall_e=stall_m=1, stall_w=0, flush_w=1, all other flushes 0. Branch and interlock conditions are suppressed.
  - lu | mdu_hz: stall_pc=stall_d=1, flush_e=1, flush_d=0 (branch flush suppressed).
  - branch_taken_D: flush_d=1.
  - Otherwise all outputs 0.
- MDU counter:
  - mdu_start_E & ~memfreeze loads MUL_CYCLES or DIV_CYCLES, per mdu_div_E.
  - Otherwise the counter decrements when nonzero, including during memfreeze.
  - A start while mdu_cnt!=0 cannot occur legally, because mdu_hz holds such an instruction in D. If it occurs, the counter reloads and the bench flags an assertion.
- Memory FSM:
  - IDLE → MEM_WAIT when dm_req_M & ~dm_ready; wait_cnt=0.
  - MEM_WAIT, dm_ready → IDLE.
  - MEM_WAIT, timeout_hit → IDLE, bus_err=1 for 1 cycle; that cycle memfreeze=0, so the pipe advances.
  - Otherwise wait_cnt++.
  - A dm_req_M drop while in MEM_WAIT → IDLE with no error.
- stall_count increments every cycle stall_pc=1 and wraps from 0xFFFFFFFF to 0.

## Timing
- Reset: mdu_cnt=0, state=IDLE, wait_cnt=0, bus_err=0, stall_count=0. While rst=1, every stall and flush output is forced to 0 and mdu_busy=0. Reset mid-operation aborts an MDU count or memory wait immediately.
- Load-use costs exactly 1 bubble: the next cycle load is in M, so lu=0.
- mult in E at cycle t with a dependent mfhi in D: stall cycles t..t+MUL_CYCLES (6 cycles at default); mfhi enters E at t+MUL_CYCLES+1.
- A memory wait of N cycles (N < MEM_TIMEOUT) freezes exactly N cycles, and MEM/WB receives N bubbles.
- A timeout freezes MEM_TIMEOUT cycles. bus_err is high on the release cycle (registered, visible the cycle after).
- Simultaneous load-use and taken branch: stall wins. The branch re-resolves the next cycle and flush_d asserts then.

## Test plan
- lw $2 in E, add $3,$2,$4 in D → cycle: stall_pc=stall_d=flush_e=1. Next cycle all 0. stall_count=1.
- lw writing $0 with D reading $0 → no stall.
- mult issued at t, mfhi in D → stall_pc=1 for t..t+5, mdu_busy falls at t+6. div with a dependent mfhi → 11 stall cycles.
- dm_req_M=1, dm_ready low 3 cycles then high → stall_m=1 and flush_w=1 for 3 cycles; state returns to IDLE; bus_err stays 0.
- dm_ready held low with MEM_TIMEOUT=4 → 4 frozen cycles, then release, a bus_err pulse, and state=IDLE.
- Taken branch concurrent with mdu_hz → flush_d=0 while stalled, flush_d=1 on the first unstalled cycle. Asserting rst mid-divide → mdu_busy=0 on the next edge.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hazard/stall controller for the five-stage pipeline
// Sequences load-use interlock, MDU occupancy and data-memory wait states with timeout.
module pipe_hazard_ctrl #(
  parameter int MUL_CYCLES  = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic        use_rs_D,
  input  logic        use_rt_D,
  input  logic        load_E,
  input  logic [4:0]  wa_E,
  input  logic        mdu_start_E,
  input  logic        mdu_div_E,
  input  logic        mdu_use_D,
  input  logic        branch_taken_D,
  input  logic        dm_req_M,
  input  logic        dm_ready,
  output logic        stall_pc,
  output logic        stall_d,
  output logic        stall_e,
  output logic        stall_m,
  output logic        stall_w,
  output logic        flush_d,
  output logic        flush_e,
  output logic        flush_w,
  output logic        mdu_busy,
  output logic        bus_err,
  output logic [31:0] stall_count
);

  typedef enum logic {IDLE, MEM_WAIT} mem_state_t;

  localparam logic [3:0] MUL_LAT   = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_LAT   = 4'(DIV_CYCLES);
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  mem_state_t state, state_next;
  logic [7:0] wait_cnt, wait_cnt_next;
  logic [3:0] mdu_cnt, mdu_cnt_next;
  logic       bus_err_next;
  logic       timeout_hit, memfreeze, lu, mdu_hz;

  assign timeout_hit = (state == MEM_WAIT) && (wait_cnt == WAIT_LAST);
  assign memfreeze   = dm_req_M && !dm_ready && !timeout_hit;
  assign lu          = load_E && (wa_E != 5'd0) &&
                       ((use_rs_D && (rs_D == wa_E)) || (use_rt_D && (rt_D == wa_E)));
  assign mdu_hz      = mdu_use_D && ((mdu_cnt != 4'd0) || mdu_start_E);
  assign mdu_busy    = !rst && (mdu_cnt != 4'd0);

  // Memory freeze outranks interlocks; an interlock outranks the branch flush.
  always_comb begin
    stall_pc = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    stall_m  = 1'b0;
    stall_w  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    flush_w  = 1'b0;
    if (!rst) begin
      if (memfreeze) begin
        stall_pc = 1'b1;
        stall_d  = 1'b1;
        stall_e  = 1'b1;
        stall_m  = 1'b1;
        flush_w  = 1'b1;
      end else if (lu || mdu_hz) begin
        stall_pc = 1'b1;
        stall_d  = 1'b1;
        flush_e  = 1'b1;
      end else if (branch_taken_D) begin
        flush_d = 1'b1;
      end
    end
  end

  always_comb begin
    mdu_cnt_next = mdu_cnt;
    if (mdu_start_E && !memfreeze) begin
      mdu_cnt_next = mdu_div_E ? DIV_LAT : MUL_LAT;
    end else if (mdu_cnt != 4'd0) begin
      mdu_cnt_next = mdu_cnt - 4'd1;
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    bus_err_next  = 1'b0;
    case (state)
      IDLE: begin
        if (dm_req_M && !dm_ready) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = 8'd0;
        end
      end
      MEM_WAIT: begin
        if (!dm_req_M || dm_ready) begin
          state_next    = IDLE;
          wait_cnt_next = 8'd0;
        end else if (timeout_hit) begin
          state_next    = IDLE;
          wait_cnt_next = 8'd0;
          bus_err_next  = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt + 8'd1;
        end
      end
      default: begin
        state_next    = IDLE;
        wait_cnt_next = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= 8'd0;
      mdu_cnt     <= 4'd0;
      bus_err     <= 1'b0;
      stall_count <= 32'd0;
    end else begin
      state       <= state_next;
      wait_cnt    <= wait_cnt_next;
      mdu_cnt     <= mdu_cnt_next;
      bus_err     <= bus_err_next;
      stall_count <= stall_count + {31'd0, stall_pc};
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
// Directed scenarios plus randomized traffic against a cycle-count reference model.
module tb_pipe_hazard_ctrl;
  localparam int MUL = 5;
  localparam int DIV = 10;
  localparam int MT  = 4;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs_D, rt_D, wa_E;
  logic use_rs_D, use_rt_D, load_E, mdu_start_E, mdu_div_E, mdu_use_D;
  logic branch_taken_D, dm_req_M, dm_ready;
  logic stall_pc, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e, flush_w;
  logic mdu_busy, bus_err;
  logic [31:0] stall_count;

  wire [7:0] ctl = {stall_pc, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e, flush_w};

  int checks = 0;
  int errors = 0;

  // Reference state: cycle index, cycle at which the MDU becomes free,
  // consecutive frozen cycles of the current access, pending bus error, stall total.
  int cyc = 0;
  int mdu_end = 0;
  int mem_waited = 0;
  bit bus_err_m = 1'b0;
  logic [31:0] cnt_m = 32'd0;

  pipe_hazard_ctrl #(.MUL_CYCLES(MUL), .DIV_CYCLES(DIV), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .rst(rst), .rs_D(rs_D), .rt_D(rt_D), .use_rs_D(use_rs_D), .use_rt_D(use_rt_D),
    .load_E(load_E), .wa_E(wa_E), .mdu_start_E(mdu_start_E), .mdu_div_E(mdu_div_E),
    .mdu_use_D(mdu_use_D), .branch_taken_D(branch_taken_D), .dm_req_M(dm_req_M),
    .dm_ready(dm_ready), .stall_pc(stall_pc), .stall_d(stall_d), .stall_e(stall_e),
    .stall_m(stall_m), .stall_w(stall_w), .flush_d(flush_d), .flush_e(flush_e),
    .flush_w(flush_w), .mdu_busy(mdu_busy), .bus_err(bus_err), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_ctl();
    bit freeze, lu, mhz;
    if (rst) return 8'h00;
    freeze = dm_req_M && !dm_ready && (mem_waited < MT);
    lu = load_E && (wa_E != 0) && ((use_rs_D && rs_D == wa_E) || (use_rt_D && rt_D == wa_E));
    mhz = mdu_use_D && ((cyc < mdu_end) || mdu_start_E);
    if (freeze) return 8'b1111_0001;
    if (lu || mhz) return 8'b1100_0010;
    if (branch_taken_D) return 8'b0000_0100;
    return 8'h00;
  endfunction

  function automatic logic exp_busy();
    return !rst && (cyc < mdu_end);
  endfunction

  task automatic tick();
    logic [7:0] e;
    e = exp_ctl();
    @(posedge clk);
    if (rst) begin
      mdu_end = 0; mem_waited = 0; bus_err_m = 1'b0; cnt_m = 32'd0;
    end else begin
      if (e[7]) cnt_m = cnt_m + 32'd1;
      bus_err_m = dm_req_M && !dm_ready && (mem_waited == MT);
      if (dm_req_M && !dm_ready) mem_waited = (mem_waited == MT) ? 0 : mem_waited + 1;
      else mem_waited = 0;
      if (mdu_start_E && !e[0]) mdu_end = cyc + (mdu_div_E ? DIV : MUL) + 1;
    end
    cyc++;
    #1;
  endtask

  task automatic clear_inputs();
    rs_D = 0; rt_D = 0; wa_E = 0; use_rs_D = 0; use_rt_D = 0; load_E = 0;
    mdu_start_E = 0; mdu_div_E = 0; mdu_use_D = 0; branch_taken_D = 0;
    dm_req_M = 0; dm_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    load_E = 1; wa_E = 5'd7; rs_D = 5'd7; use_rs_D = 1; branch_taken_D = 1;
    dm_req_M = 1; dm_ready = 0;
    tick();
    @(negedge clk);
    checks++;
    if (ctl !== 8'h00 || mdu_busy !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got %b/%b want 00000000/0", ctl, mdu_busy);
    end
    checks++;
    if (bus_err !== 1'b0 || stall_count !== 32'd0) begin
      errors++; $display("FAIL reset_regs got bus_err=%b cnt=%0d want 0/0", bus_err, stall_count);
    end
    tick();
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_load_use();
    load_E = 1; wa_E = 5'd2; rs_D = 5'd2; use_rs_D = 1; rt_D = 5'd4; use_rt_D = 1;
    @(negedge clk);
    checks++;
    if (ctl !== 8'b1100_0010 || ctl !== exp_ctl()) begin
      errors++; $display("FAIL load_use_stall got %b want 11000010", ctl);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (ctl !== 8'h00 || stall_count !== 32'd1) begin
      errors++; $display("FAIL load_use_release got %b cnt=%0d want 00000000 cnt=1", ctl, stall_count);
    end
    tick();
    load_E = 1; wa_E = 5'd0; rs_D = 5'd0; use_rs_D = 1; rt_D = 5'd0; use_rt_D = 1;
    @(negedge clk);
    checks++;
    if (ctl !== 8'h00) begin
      errors++; $display("FAIL load_use_r0 got %b want 00000000", ctl);
    end
    tick();
    clear_inputs();
  endtask

  task automatic run_mdu(input bit div, input bit branch, input string name);
    int n;
    bit done;
    n = 0; done = 0;
    mdu_start_E = 1; mdu_div_E = div; mdu_use_D = 1; branch_taken_D = branch;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      checks++;
      if (ctl !== exp_ctl() || mdu_busy !== exp_busy()) begin
        errors++; $display("FAIL %s_cycle%0d got %b/%b want %b/%b", name, i, ctl, mdu_busy, exp_ctl(), exp_busy());
      end
      if (stall_pc) begin
        n++;
        if (branch) begin
          checks++;
          if (flush_d !== 1'b0) begin
            errors++; $display("FAIL %s_flush_suppressed got %b want 0", name, flush_d);
          end
        end
      end else begin
        done = 1;
        checks++;
        if (mdu_busy !== 1'b0 || flush_d !== branch) begin
          errors++; $display("FAIL %s_release got busy=%b flush_d=%b want 0/%b", name, mdu_busy, flush_d, branch);
        end
      end
      tick();
      mdu_start_E = 0;
    end
    checks++;
    if (n !== (div ? DIV : MUL) + 1) begin
      errors++; $display("FAIL %s_stall_cycles got %0d want %0d", name, n, (div ? DIV : MUL) + 1);
    end
    clear_inputs();
  endtask

  task automatic test_mdu();
    run_mdu(1'b0, 1'b0, "mult");
    run_mdu(1'b1, 1'b0, "div");
  endtask

  task automatic test_branch_mdu();
    run_mdu(1'b0, 1'b1, "branch_mdu");
  endtask

  task automatic test_mem_wait();
    logic [31:0] c0;
    dm_req_M = 1; dm_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) c0 = stall_count;
      checks++;
      if (stall_m !== 1'b1 || flush_w !== 1'b1 || ctl !== exp_ctl()) begin
        errors++; $display("FAIL mem_wait_freeze%0d got %b want %b", i, ctl, exp_ctl());
      end
      tick();
    end
    dm_ready = 1;
    @(negedge clk);
    checks++;
    if (ctl !== 8'h00 || stall_count !== c0 + 32'd3) begin
      errors++; $display("FAIL mem_wait_release got %b cnt+%0d want 00000000 cnt+3", ctl, stall_count - c0);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (bus_err !== 1'b0) begin
      errors++; $display("FAIL mem_wait_no_err got %b want 0", bus_err);
    end
    tick();
  endtask

  task automatic test_timeout();
    int n;
    bit done;
    n = 0; done = 0;
    dm_req_M = 1; dm_ready = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      checks++;
      if (ctl !== exp_ctl() || bus_err !== 1'b0) begin
        errors++; $display("FAIL timeout_cycle%0d got %b err=%b want %b err=0", i, ctl, bus_err, exp_ctl());
      end
      if (stall_m) n++;
      else done = 1;
      tick();
    end
    checks++;
    if (n !== MT || !done) begin
      errors++; $display("FAIL timeout_frozen got %0d want %0d", n, MT);
    end
    dm_req_M = 0;
    @(negedge clk);
    checks++;
    if (bus_err !== 1'b1 || ctl !== 8'h00) begin
      errors++; $display("FAIL timeout_bus_err got %b/%b want 1/00000000", bus_err, ctl);
    end
    tick();
    dm_req_M = 1; dm_ready = 0;
    @(negedge clk);
    checks++;
    if (bus_err !== 1'b0 || stall_m !== 1'b1) begin
      errors++; $display("FAIL timeout_pulse_idle got err=%b stall_m=%b want 0/1", bus_err, stall_m);
    end
    dm_ready = 1;
    tick();
    clear_inputs();
  endtask

  task automatic test_lu_branch();
    load_E = 1; wa_E = 5'd9; rt_D = 5'd9; use_rt_D = 1; branch_taken_D = 1;
    @(negedge clk);
    checks++;
    if (ctl !== 8'b1100_0010) begin
      errors++; $display("FAIL lu_branch_stall got %b want 11000010", ctl);
    end
    tick();
    load_E = 0;
    @(negedge clk);
    checks++;
    if (ctl !== 8'b0000_0100) begin
      errors++; $display("FAIL lu_branch_flush got %b want 00000100", ctl);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_rst_mid_div();
    mdu_start_E = 1; mdu_div_E = 1;
    tick();
    clear_inputs();
    tick(); tick();
    @(negedge clk);
    checks++;
    if (mdu_busy !== 1'b1) begin
      errors++; $display("FAIL rst_div_busy got %b want 1", mdu_busy);
    end
    rst = 1;
    tick();
    rst = 0;
    mdu_use_D = 1;
    @(negedge clk);
    checks++;
    if (mdu_busy !== 1'b0 || ctl !== 8'h00 || stall_count !== 32'd0) begin
      errors++; $display("FAIL rst_div_abort got busy=%b ctl=%b cnt=%0d want 0/00000000/0", mdu_busy, ctl, stall_count);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_random();
    bit hold_req;
    hold_req = 0;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      rs_D = 5'($urandom_range(0, 3)); rt_D = 5'($urandom_range(0, 3));
      wa_E = 5'($urandom_range(0, 3));
      use_rs_D = $urandom_range(0, 1); use_rt_D = $urandom_range(0, 1);
      load_E = ($urandom_range(0, 3) == 0);
      mdu_use_D = ($urandom_range(0, 3) == 0);
      mdu_div_E = $urandom_range(0, 1);
      mdu_start_E = !(cyc < mdu_end) && ($urandom_range(0, 7) == 0);
      branch_taken_D = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 5) == 0) hold_req = !hold_req;
      dm_req_M = hold_req;
      dm_ready = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      checks++;
      if (ctl !== exp_ctl() || mdu_busy !== exp_busy() || bus_err !== bus_err_m || stall_count !== cnt_m) begin
        errors++;
        $display("FAIL random%0d got ctl=%b busy=%b err=%b cnt=%0d want ctl=%b busy=%b err=%b cnt=%0d",
                 i, ctl, mdu_busy, bus_err, stall_count, exp_ctl(), exp_busy(), bus_err_m, cnt_m);
      end
      tick();
    end
    rst = 0;
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_mdu();
    test_mem_wait();
    test_timeout();
    test_branch_mdu();
    test_lu_branch();
    test_rst_mid_div();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
